div_arbiter: RTL and testbench

- Shares one unsigned divider instance (valid_in/valid_out handshake, in-order results) between NUM_REQ image-pipeline requesters, e.g. the Gaussian blur normaliser and a later gradient normaliser.
- Round-robin arbitration on requests, registered issue to the divider, and a tag FIFO that routes each quotient back to its originating requester.
- Sits between the canny-stage filter blocks and the shared divider.

---
 rtl/div_arbiter.sv | 157 +++++++++++++++
 tb/tb_div_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
//==============================================================================
// div_arbiter : round-robin sharing of one in-order divider among NUM_REQ
// requesters, with a tag FIFO steering each quotient back to its requester.
// Optional: `define DIV_ARB_ZERO_GUARD_EN to saturate divide-by-zero requests.
// Rev 1.0
//==============================================================================
`default_nettype none

module div_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int DIVIDEND_WIDTH  = 16,
    parameter int DIVISOR_WIDTH   = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ*DIVIDEND_WIDTH-1:0]   req_dividend,
    input  logic [NUM_REQ*DIVISOR_WIDTH-1:0]    req_divisor,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic [NUM_REQ-1:0]                  resp_valid,
    output logic [DIVIDEND_WIDTH-1:0]           resp_quotient,
    output logic                                div_valid_in,
    output logic [DIVIDEND_WIDTH-1:0]           div_dividend,
    output logic [DIVISOR_WIDTH-1:0]            div_divisor,
    input  logic                                div_valid_out,
    input  logic [DIVIDEND_WIDTH-1:0]           div_quotient,
    output logic                                busy,
    output logic                                protocol_err
);

    localparam int TW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
    localparam logic [TW-1:0] LAST_REQ = TW'(NUM_REQ - 1);
    localparam logic [AW-1:0] LAST_PTR = AW'(MAX_OUTSTANDING - 1);

    logic [TW-1:0]             ptr_q, ptr_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [AW-1:0]             wr_q, rd_q;
    logic [TW-1:0]             tag_q [MAX_OUTSTANDING];
    logic                      div_valid_q;
    logic [DIVIDEND_WIDTH-1:0] div_dividend_q;
    logic [DIVISOR_WIDTH-1:0]  div_divisor_q;
    logic [NUM_REQ-1:0]        resp_valid_q, resp_valid_d;
    logic [DIVIDEND_WIDTH-1:0] resp_quotient_q;
    logic                      perr_q;

    logic                      can_issue;
    logic                      gnt_vld;
    logic [TW-1:0]             gnt_idx;
    int                        scan_idx;
    logic [DIVIDEND_WIDTH-1:0] iss_dividend;
    logic [DIVISOR_WIDTH-1:0]  iss_divisor;
    logic                      pop;

    // A result arriving this cycle frees its slot in time for a same-cycle grant.
    assign can_issue = (cnt_q < MAX_CNT) || div_valid_out;
    assign pop       = div_valid_out && (cnt_q != '0);

    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = int'(ptr_q) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!gnt_vld && req_valid[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = TW'(scan_idx);
            end
        end
        gnt_vld   = gnt_vld && can_issue && reset;
        req_ready = '0;
        if (gnt_vld) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        iss_dividend = req_dividend[int'(gnt_idx)*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
        iss_divisor  = req_divisor[int'(gnt_idx)*DIVISOR_WIDTH +: DIVISOR_WIDTH];
`ifdef DIV_ARB_ZERO_GUARD_EN
        // all-ones / 1 returns a saturated quotient while keeping the tag slot
        if (iss_divisor == '0) begin
            iss_dividend = '1;
            iss_divisor  = DIVISOR_WIDTH'(1);
        end
`endif
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld) begin
            ptr_d = (gnt_idx == LAST_REQ) ? '0 : gnt_idx + TW'(1);
        end
        case ({gnt_vld, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        resp_valid_d = '0;
        if (pop) begin
            resp_valid_d[tag_q[rd_q]] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q           <= '0;
            cnt_q           <= '0;
            wr_q            <= '0;
            rd_q            <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                tag_q[i] <= '0;
            end
            div_valid_q     <= 1'b0;
            div_dividend_q  <= '0;
            div_divisor_q   <= '0;
            resp_valid_q    <= '0;
            resp_quotient_q <= '0;
            perr_q          <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            div_valid_q  <= gnt_vld;
            resp_valid_q <= resp_valid_d;
            if (gnt_vld) begin
                div_dividend_q <= iss_dividend;
                div_divisor_q  <= iss_divisor;
                tag_q[wr_q]    <= gnt_idx;
                wr_q           <= (wr_q == LAST_PTR) ? '0 : wr_q + AW'(1);
            end
            if (pop) begin
                resp_quotient_q <= div_quotient;
                rd_q            <= (rd_q == LAST_PTR) ? '0 : rd_q + AW'(1);
            end
            if (div_valid_out && (cnt_q == '0)) begin
                perr_q <= 1'b1;
            end
        end
    end

    assign resp_valid    = resp_valid_q;
    assign resp_quotient = resp_quotient_q;
    assign div_valid_in  = div_valid_q;
    assign div_dividend  = div_dividend_q;
    assign div_divisor   = div_divisor_q;
    assign busy          = (cnt_q != '0);
    assign protocol_err  = perr_q;

endmodule

`default_nettype wire

// File: tb/tb_div_arbiter.sv
//==============================================================================
// tb_div_arbiter : scoreboard bench for div_arbiter with a behavioural
// in-order divider (latency LAT, stallable). Rev 1.0
//==============================================================================
`default_nettype none

module tb_div_arbiter;

    localparam int LAT = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [31:0] req_dividend = '0;
    logic [15:0] req_divisor = '0;
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic [15:0] resp_quotient;
    logic        div_valid_in;
    logic [15:0] div_dividend;
    logic [7:0]  div_divisor;
    logic        div_valid_out = 1'b0;
    logic [15:0] div_quotient = '0;
    logic        busy;
    logic        protocol_err;

    div_arbiter #(
        .NUM_REQ(2), .DIVIDEND_WIDTH(16), .DIVISOR_WIDTH(8), .MAX_OUTSTANDING(4)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_dividend(req_dividend), .req_divisor(req_divisor),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_quotient(resp_quotient),
        .div_valid_in(div_valid_in), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_valid_out(div_valid_out), .div_quotient(div_quotient),
        .busy(busy), .protocol_err(protocol_err)
    );

    always #5 clock = ~clock;

    typedef struct packed { logic [15:0] dvd; logic [7:0] dvs; } op_t;
    typedef struct { int idx; logic [15:0] q; int g; } sb_t;
    typedef struct { int cyc; logic [15:0] dvd; logic [7:0] dvs; } iss_t;
    typedef struct { logic [15:0] q; int rdy; } dq_t;

    op_t  rq [2][$];
    sb_t  sb [$];
    iss_t iq [$];
    dq_t  dq [$];
    int   gl [$];

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   nresp [2];
    bit   stall = 0, release_one = 0, force_spur = 0, chk_lat = 0;
    logic [1:0] rdy_s;
    logic       busy_s;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] model_div(input logic [15:0] a, input logic [7:0] b);
        return (b == 8'd0) ? 16'h1234 : a / {8'd0, b};
    endfunction

    function automatic op_t issued_op(input op_t o);
        op_t r = o;
`ifdef DIV_ARB_ZERO_GUARD_EN
        if (o.dvs == 8'd0) begin
            r.dvd = 16'hFFFF;
            r.dvs = 8'd1;
        end
`endif
        return r;
    endfunction

    task automatic step();
        op_t  o;
        sb_t  s;
        iss_t e;
        dq_t  d;
        @(negedge clock);
        cyc++;
        div_valid_out = 1'b0;
        if (force_spur) begin
            div_valid_out = 1'b1;
            div_quotient  = 16'hBEEF;
            force_spur    = 0;
        end else if ((!stall || release_one) && dq.size() > 0 && dq[0].rdy <= cyc) begin
            d = dq.pop_front();
            div_valid_out = 1'b1;
            div_quotient  = d.q;
            release_one   = 0;
        end
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = (rq[i].size() > 0);
            if (rq[i].size() > 0) begin
                req_dividend[i*16 +: 16] = rq[i][0].dvd;
                req_divisor[i*8 +: 8]    = rq[i][0].dvs;
            end
        end
        #1;
        if (div_valid_in) begin
            if (iq.size() == 0) begin
                check_eq("issue_unexpected", 1, 0);
            end else begin
                e = iq.pop_front();
                check_eq("issue_cycle", cyc, e.cyc);
                check_eq("issue_dividend", div_dividend, e.dvd);
                check_eq("issue_divisor", div_divisor, e.dvs);
            end
            d.q   = model_div(div_dividend, div_divisor);
            d.rdy = cyc + LAT + 1;
            dq.push_back(d);
        end
        if (resp_valid != 2'b00) begin
            if (sb.size() == 0) begin
                check_eq("resp_unexpected", resp_valid, 0);
            end else begin
                s = sb.pop_front();
                check_eq("resp_index", resp_valid, 32'd1 << s.idx);
                check_eq("resp_quotient", resp_quotient, s.q);
                if (chk_lat) check_eq("resp_latency", cyc - s.g, LAT + 2);
                nresp[s.idx]++;
            end
        end
        rdy_s  = req_ready;
        busy_s = busy;
        for (int i = 0; i < 2; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                o     = rq[i].pop_front();
                s.idx = i;
                s.q   = model_div(issued_op(o).dvd, issued_op(o).dvs);
                s.g   = cyc + 1;
                sb.push_back(s);
                e.cyc = cyc + 1;
                e.dvd = issued_op(o).dvd;
                e.dvs = issued_op(o).dvs;
                iq.push_back(e);
                gl.push_back(i);
            end
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((sb.size() > 0 || rq[0].size() > 0 || rq[1].size() > 0) && n < budget) begin
            step();
            n++;
        end
        check_eq("drain_in_budget", (n < budget), 1);
        repeat (3) step();
    endtask

    task automatic push_op(input int i, input logic [15:0] a, input logic [7:0] b);
        op_t o;
        o.dvd = a;
        o.dvs = b;
        rq[i].push_back(o);
    endtask

    initial begin
        int n;
        nresp[0] = 0;
        nresp[1] = 0;

        // reset state
        repeat (3) step();
        check_eq("rst_resp_valid", resp_valid, 0);
        check_eq("rst_div_valid", div_valid_in, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_perr", protocol_err, 0);
        reset = 1'b1;
        repeat (2) step();

        // single request 300/12 with end-to-end latency check
        chk_lat = 1;
        push_op(0, 16'd300, 8'd12);
        step();
        check_eq("single_ready_same_cycle", rdy_s, 2'b01);
        drain(50);
        check_eq("single_resp_count", nresp[0], 1);
        chk_lat = 0;

        // contention: both requesters hold valid, 8 ops each
        gl.delete();
        nresp[0] = 0;
        nresp[1] = 0;
        for (int k = 0; k < 8; k++) begin
            push_op(0, 16'($urandom_range(0, 65535)), 8'($urandom_range(1, 255)));
            push_op(1, 16'($urandom_range(0, 65535)), 8'($urandom_range(1, 255)));
        end
        drain(300);
        check_eq("cont_grants", gl.size(), 16);
        for (int k = 1; k < gl.size(); k++) begin
            check_eq("cont_alternate", (gl[k] != gl[k-1]), 1);
        end
        check_eq("cont_resp0", nresp[0], 8);
        check_eq("cont_resp1", nresp[1], 8);

        // capacity with a stalled divider
        gl.delete();
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            push_op(0, 16'd1000 + 16'(k), 8'd7);
            push_op(1, 16'd2000 + 16'(k), 8'd9);
        end
        repeat (8) step();
        check_eq("cap_grants", gl.size(), 4);
        check_eq("cap_ready_low", rdy_s, 0);
        check_eq("cap_busy", busy_s, 1);
        release_one = 1;
        step();
        check_eq("cap_pop_grant", (rdy_s != 2'b00), 1);
        step();
        check_eq("cap_still_full", rdy_s, 0);
        check_eq("cap_grants_after", gl.size(), 5);
        stall = 0;
        drain(200);

        // zero divisor
        push_op(1, 16'd100, 8'd0);
        drain(50);

        // spurious divider result while idle
        n = nresp[0] + nresp[1];
        force_spur = 1;
        repeat (3) step();
        check_eq("spur_perr", protocol_err, 1);
        check_eq("spur_no_resp", nresp[0] + nresp[1], n);
        push_op(0, 16'd77, 8'd7);
        drain(50);
        check_eq("spur_perr_sticky", protocol_err, 1);

        // reset with three ops in flight; pointer left at 1 beforehand
        stall = 1;
        gl.delete();
        for (int k = 0; k < 3; k++) push_op(0, 16'd500, 8'd5);
        n = 0;
        while (gl.size() < 3 && n < 30) begin
            step();
            n++;
        end
        check_eq("mid_issued", gl.size(), 3);
        step();
        check_eq("mid_busy", busy_s, 1);
        reset = 1'b0;
        sb.delete();
        iq.delete();
        dq.delete();
        rq[0].delete();
        rq[1].delete();
        stall = 0;
        repeat (2) step();
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_div_valid", div_valid_in, 0);
        check_eq("mid_rst_dividend", div_dividend, 0);
        check_eq("mid_rst_resp_q", resp_quotient, 0);
        check_eq("mid_rst_perr", protocol_err, 0);
        check_eq("mid_rst_ready", rdy_s, 0);
        reset = 1'b1;
        step();
        gl.delete();
        push_op(0, 16'd900, 8'd30);
        push_op(1, 16'd901, 8'd1);
        chk_lat = 1;
        drain(50);
        if (gl.size() > 0) check_eq("post_rst_first_grant", gl[0], 0);
        else check_eq("post_rst_grant_missing", 0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
